// File: rtl/encode_mul_arb_pkg.sv
// Shared constants and helpers for the encoder multiplier-sharing arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   A_W / B_W / P_W : operand and product widths; NUM_REQ : default requester count
//   next_ptr        : round-robin pointer advance with modulo-n wrap
package encode_mul_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int A_W     = 40;
  localparam int B_W     = 22;
  localparam int P_W     = 61;

  // Pointer that follows a grant to requester win; wraps without a divider
  // so non-power-of-two requester counts stay cheap.
  function automatic int unsigned next_ptr(input int unsigned win,
                                           input int unsigned n = NUM_REQ);
    return (win + 1 >= n) ? 32'd0 : win + 1;
  endfunction

endpackage

// File: rtl/encode_mul_pipe.sv
// Two-stage signed x unsigned multiply pipeline: operand register, then product register.
// Latency: 2 cycles from load to product valid while ce stays high.
// Backpressure: ce low freezes every register (valid, data and tag) in both stages.
//   in : clk, reset, ce, load_vld, load_a (signed), load_b (unsigned), load_id
//   out: s1_vld (stage-1 occupancy), p_vld, p_dat (low P_W bits of product), p_id
module encode_mul_pipe #(
  parameter int A_W  = 40,
  parameter int B_W  = 22,
  parameter int P_W  = 61,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  input  logic            load_vld,
  input  logic [A_W-1:0]  load_a,
  input  logic [B_W-1:0]  load_b,
  input  logic [ID_W-1:0] load_id,
  output logic            s1_vld,
  output logic            p_vld,
  output logic [P_W-1:0]  p_dat,
  output logic [ID_W-1:0] p_id
);

  localparam int FULL_W = A_W + B_W + 1;

  logic [A_W-1:0]    s1_a;
  logic [B_W-1:0]    s1_b;
  logic [ID_W-1:0]   s1_id;
  logic [FULL_W-1:0] prod_full;

  // b gets a zero sign bit so the multiply is signed x unsigned; the
  // result is exact at FULL_W and then cut to the low P_W bits.
  assign prod_full = $signed(s1_a) * $signed({1'b0, s1_b});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_id  <= '0;
    end else if (ce) begin
      s1_vld <= load_vld;
      // Operand fields only move on a real load; idle cycles just clear valid.
      if (load_vld) begin
        s1_a  <= load_a;
        s1_b  <= load_b;
        s1_id <= load_id;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_vld <= 1'b0;
      p_dat <= '0;
      p_id  <= '0;
    end else if (ce) begin
      p_vld <= s1_vld;
      p_dat <= prod_full[P_W-1:0];
      p_id  <= s1_id;
    end
  end

endmodule

// File: rtl/encode_mul_share_arb.sv
// Round-robin arbiter sharing one pipelined signed x unsigned multiplier among NUM_REQ requesters.
// Latency: accept in cycle t -> rsp_valid in cycle t+2 without stalls; one product per cycle.
// Backpressure: rsp_valid & !rsp_ready freezes both stages and drops every req_ready that cycle.
//   in : clk, reset, req_valid[NUM_REQ], req_a[NUM_REQ*A_W], req_b[NUM_REQ*B_W], rsp_ready
//   out: req_ready[NUM_REQ] (one-hot or zero), rsp_valid, rsp_data[P_W], rsp_id[ID_W], busy
module encode_mul_share_arb #(
  parameter int NUM_REQ = encode_mul_arb_pkg::NUM_REQ,
  parameter int A_W     = encode_mul_arb_pkg::A_W,
  parameter int B_W     = encode_mul_arb_pkg::B_W,
  parameter int P_W     = encode_mul_arb_pkg::P_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [P_W-1:0]         rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  import encode_mul_arb_pkg::*;

  logic            ce;
  logic            any_vld;
  logic            accept;
  logic            s1_vld;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] idx;
  int              sum;

  logic [A_W-1:0] a_arr [NUM_REQ];
  logic [B_W-1:0] b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*A_W +: A_W];
    assign b_arr[i] = req_b[i*B_W +: B_W];
  end

  // The output register can take new data when it is empty or draining now,
  // so a response handshake and a new accept can share one cycle.
  assign ce = !rsp_valid | rsp_ready;

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    win     = '0;
    any_vld = 1'b0;
    idx     = '0;
    sum     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (!any_vld && req_valid[idx]) begin
        any_vld = 1'b1;
        win     = idx;
      end
    end
  end

  // reset is in the accept term so ready drops the instant reset rises,
  // without waiting for a clock edge.
  assign accept    = any_vld & ce & !reset;
  assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ID_W'(next_ptr(32'(win), NUM_REQ));
    end
  end

  encode_mul_pipe #(
    .A_W  (A_W),
    .B_W  (B_W),
    .P_W  (P_W),
    .ID_W (ID_W)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .load_vld (accept),
    .load_a   (a_arr[win]),
    .load_b   (b_arr[win]),
    .load_id  (win),
    .s1_vld   (s1_vld),
    .p_vld    (rsp_valid),
    .p_dat    (rsp_data),
    .p_id     (rsp_id)
  );

  assign busy = s1_vld | rsp_valid;

endmodule

// File: tb/tb_encode_mul_share_arb.sv
// Directed bench for encode_mul_share_arb with hand-computed products.
// Latency: inputs driven just after each falling edge, outputs sampled 1 time unit later.
// Backpressure: rsp_ready held low for five cycles in one scenario.
module tb_encode_mul_share_arb;

  localparam int NR = 4;
  localparam int AW = 40;
  localparam int BW = 22;
  localparam int PW = 61;

  // Hand-computed products of the fixed per-requester operands.
  localparam logic [PW-1:0] P0     = 61'd21;             //        7 * 3
  localparam logic [PW-1:0] P1     = -61'sd100000;       //     -100 * 1000
  localparam logic [PW-1:0] P2     = 61'd246912;         //   123456 * 2
  localparam logic [PW-1:0] P3     = -61'sd4194303;      //       -1 * (2^22-1)
  localparam logic [PW-1:0] P_M15  = 61'h1FFF_FFFF_FFFF_FFF1;
  localparam logic [PW-1:0] P_EXT  = 61'h80_0000_0000;   // -2^39*(2^22-1) mod 2^61 = 2^39

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_a;
  logic [NR*BW-1:0]  req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [PW-1:0]     rsp_data;
  logic [1:0]        rsp_id;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  encode_mul_share_arb dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
  endtask

  function automatic logic [PW-1:0] exp_prod(input int id);
    case (id)
      0:       return P0;
      1:       return P1;
      2:       return P2;
      default: return P3;
    endcase
  endfunction

  // Step to just after the next falling edge; the caller then drives inputs.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int g;
    int r;

    reset     = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;

    // ---- reset state, with every requester valid -----------------------
    step(); step();
    settle();
    check("rst_rdy",   64'(req_ready), 64'h0);
    check("rst_vld",   64'(rsp_valid), 64'h0);
    check("rst_busy",  64'(busy),      64'h0);
    check("rst_data",  64'(rsp_data),  64'h0);
    check("rst_id",    64'(rsp_id),    64'h0);

    step();
    req_valid = '0;
    reset     = 1'b0;

    // ---- single request: -3 * 5 ----------------------------------------
    step();
    set_op(0, -40'sd3, 22'd5);
    req_valid = 4'b0001;
    settle();
    check("single_rdy", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    settle();
    check("single_rdy_drop", 64'(req_ready), 64'h0);
    check("single_s1_busy",  64'(busy),      64'h1);
    check("single_s1_vld",   64'(rsp_valid), 64'h0);
    step();
    settle();
    check("single_vld",  64'(rsp_valid), 64'h1);
    check("single_data", 64'(rsp_data),  64'(P_M15));
    check("single_id",   64'(rsp_id),    64'h0);
    step();
    settle();
    check("single_done_vld",  64'(rsp_valid), 64'h0);
    check("single_done_busy", 64'(busy),      64'h0);

    // ---- all four continuously valid; ptr is 1 after the single grant ---
    set_op(0, 40'sd7,      22'd3);
    set_op(1, -40'sd100,   22'd1000);
    set_op(2, 40'sd123456, 22'd2);
    set_op(3, -40'sd1,     22'h3F_FFFF);
    for (int c = 0; c < 10; c++) begin
      step();
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      settle();
      if (c < 8) begin
        g = (1 + c) % 4;
        check("rr_grant", 64'(req_ready), 64'(4'b0001 << g));
      end else begin
        check("rr_idle_rdy", 64'(req_ready), 64'h0);
      end
      if (c >= 2) begin
        r = (c - 1) % 4;
        check("rr_vld",  64'(rsp_valid), 64'h1);
        check("rr_id",   64'(rsp_id),    64'(r));
        check("rr_data", 64'(rsp_data),  64'(exp_prod(r)));
      end
    end
    step();
    settle();
    check("rr_drain_vld",  64'(rsp_valid), 64'h0);
    check("rr_drain_busy", 64'(busy),      64'h0);

    // ---- backpressure: ptr is 1 ---------------------------------------
    req_valid = 4'b0010;
    settle();
    check("bp_grant1", 64'(req_ready), 64'h2);
    step();
    req_valid = 4'b0100;
    settle();
    check("bp_grant2", 64'(req_ready), 64'h4);
    for (int c = 0; c < 5; c++) begin
      step();
      rsp_ready = 1'b0;
      req_valid = 4'b1000;
      settle();
      check("bp_hold_rdy",  64'(req_ready), 64'h0);
      check("bp_hold_vld",  64'(rsp_valid), 64'h1);
      check("bp_hold_id",   64'(rsp_id),    64'h1);
      check("bp_hold_data", 64'(rsp_data),  64'(P1));
      check("bp_hold_busy", 64'(busy),      64'h1);
    end
    step();
    rsp_ready = 1'b1;
    settle();
    check("bp_rel_grant", 64'(req_ready), 64'h8);
    check("bp_rel_id",    64'(rsp_id),    64'h1);
    step();
    req_valid = '0;
    settle();
    check("bp_next_vld",  64'(rsp_valid), 64'h1);
    check("bp_next_id",   64'(rsp_id),    64'h2);
    check("bp_next_data", 64'(rsp_data),  64'(P2));
    step();
    settle();
    check("bp_last_vld",  64'(rsp_valid), 64'h1);
    check("bp_last_id",   64'(rsp_id),    64'h3);
    check("bp_last_data", 64'(rsp_data),  64'(P3));
    step();
    settle();
    check("bp_empty", 64'(busy), 64'h0);

    // ---- pointer wrap and operand extremes: ptr is 0 ------------------
    set_op(2, 40'h80_0000_0000, 22'h3F_FFFF);
    req_valid = 4'b0100;
    settle();
    check("wrap_pre", 64'(req_ready), 64'h4);
    step();
    set_op(3, 40'h7F_FFFF_FFFF, 22'd0);
    req_valid = 4'b1001;
    settle();
    check("wrap_g3", 64'(req_ready), 64'h8);
    step();
    settle();
    check("wrap_g0", 64'(req_ready), 64'h1);
    check("ext_neg_id",   64'(rsp_id),   64'h2);
    check("ext_neg_data", 64'(rsp_data), 64'(P_EXT));
    step();
    req_valid = '0;
    settle();
    check("ext_zero_id",   64'(rsp_id),   64'h3);
    check("ext_zero_data", 64'(rsp_data), 64'h0);
    step();
    settle();
    check("wrap_r0_id",   64'(rsp_id),   64'h0);
    check("wrap_r0_data", 64'(rsp_data), 64'(P0));
    step();
    req_valid = 4'b1111;
    settle();
    check("wrap_ptr1", 64'(req_ready), 64'h2);

    // ---- reset mid-operation ------------------------------------------
    step();
    settle();
    check("mid_grant2", 64'(req_ready), 64'h4);
    step();
    settle();
    check("mid_full_vld",  64'(rsp_valid), 64'h1);
    check("mid_full_busy", 64'(busy),      64'h1);
    reset = 1'b1;
    settle();
    check("mid_rst_vld",  64'(rsp_valid), 64'h0);
    check("mid_rst_busy", 64'(busy),      64'h0);
    check("mid_rst_rdy",  64'(req_ready), 64'h0);
    check("mid_rst_data", 64'(rsp_data),  64'h0);
    step(); step();
    req_valid = '0;
    reset     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      settle();
      check("post_rst_vld",  64'(rsp_valid), 64'h0);
      check("post_rst_busy", 64'(busy),      64'h0);
    end
    req_valid = 4'b1111;
    settle();
    check("post_rst_grant", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    step();
    settle();
    check("post_rst_rsp_id",   64'(rsp_id),   64'h0);
    check("post_rst_rsp_data", 64'(rsp_data), 64'(P0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
